// File: rtl/key_encoder_eight.sv
// key_encoder_eight: turns 8 raw active-high key lines into a 3-bit key code.
// The lines are synchronised, debounced and priority-encoded (highest index
// wins). Each new press event is presented on code/valid and held until ack.
module key_encoder_eight #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic       overrun,
  output logic       held
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    cand;
  logic [7:0]    stable;
  logic [CW-1:0] cnt;
  logic [2:0]    enc;
  logic [2:0]    last_enc;
  logic          fire;
  state_t        state;

  // Two-flop synchroniser; nothing else looks at the raw key lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 8'h00;
      s2 <= 8'h00;
    end else begin
      s1 <= keys;
      s2 <= s1;
    end
  end

  // Debounce: a vector must stay unchanged for DEBOUNCE_CYCLES clocks to be
  // accepted; the counter saturates at the accept value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= 8'h00;
      cnt    <= '0;
      stable <= 8'h00;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Priority encoder: the highest pressed index wins, zero when nothing is down.
  always_comb begin
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (stable[i]) enc = 3'(i);
    end
  end

  // A press event fires on the first press, or when the winning key changes
  // while something stays held. Releases never fire.
  always_comb begin
    fire = 1'b0;
    if (stable != 8'h00) begin
      if (state == ST_IDLE)      fire = 1'b1;
      else if (enc != last_enc)  fire = 1'b1;
    end
  end

  // Press-tracking FSM with the registered valid/ack handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_enc <= 3'd0;
      code     <= 3'd0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      held     <= 1'b0;
    end else begin
      held <= |stable;

      if (stable == 8'h00) state <= ST_IDLE;
      else                 state <= ST_HELD;

      if (fire) begin
        last_enc <= enc;
        code     <= enc;
        valid    <= 1'b1;
        // Overwriting an unacknowledged event is an overrun; an ack on the
        // same edge means the old event was consumed in time.
        if (valid && !ack)     overrun <= 1'b1;
        else if (valid && ack) overrun <= 1'b0;
      end else if (valid && ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
